// File: rtl/score_display.sv
// score_display
//   Drives a 4-digit, active-low, multiplexed 7-segment display for a
//   two-player score game. Player 1's score is shown on the leftmost digit
//   and player 2's on the rightmost; the middle two digits stay blank.
//   When a winner is reported the winner's digit is forced to 5 and blinks
//   for HOLD_BLINKS phase toggles, then stays steady with match_over raised
//   until the finish code returns to "playing".
//
// Parameters
//   SCAN_DIV     clk cycles per digit-scan step
//   BLINK_DIV    clk cycles per blink-phase toggle
//   HOLD_BLINKS  blink-phase toggles before the banner goes steady
//
// Ports
//   clk             in   system clock, rising edge
//   total_reset     in   asynchronous active-low reset
//   current_score1  in   [3:0] player-1 score (asynchronous to clk)
//   current_score2  in   [3:0] player-2 score (asynchronous to clk)
//   finish          in   [1:0] 0 playing, 1 p1 won, 2 p2 won, 3 same as 0
//   seg             out  [6:0] segments gfedcba, active-low
//   an              out  [3:0] digit anodes, active-low, one-hot
//   winner_led      out  [1:0] bit0 p1 won, bit1 p2 won
//   match_over      out  high while the banner is steady
module score_display #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_DIV   = 12500000,
  parameter int HOLD_BLINKS = 6
) (
  input  logic       clk,
  input  logic       total_reset,
  input  logic [3:0] current_score1,
  input  logic [3:0] current_score2,
  input  logic [1:0] finish,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [1:0] winner_led,
  output logic       match_over
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TW = $clog2(HOLD_BLINKS + 1);

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_BLINKS - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    WIN_BLINK = 2'd1,
    WAIT_CLR  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      sync1_q, sync2_q, sync3_q, acc_q;
  logic [3:0]      d1_q, d1_d, d2_q, d2_d;
  logic            winner_q, winner_d;
  logic [SW-1:0]   scanCnt_q, scanCnt_d;
  logic [1:0]      digitIdx_q, digitIdx_d;
  logic [BW-1:0]   blinkCnt_q, blinkCnt_d;
  logic            phase_q, phase_d;
  logic [TW-1:0]   toggles_q, toggles_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic [1:0]      led_q, led_d;
  logic            over_q, over_d;

  logic [1:0]      accFinish;
  logic [3:0]      accScore1, accScore2;
  logic            finWin;
  logic            winnerBlank;

  assign accFinish = acc_q[9:8];
  assign accScore1 = acc_q[7:4];
  assign accScore2 = acc_q[3:0];
  // Codes 0 and 3 both mean "playing"; only 1 and 2 report a winner.
  assign finWin    = (accFinish == 2'd1) || (accFinish == 2'd2);

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0000110;
    endcase
    return s;
  endfunction

  // Input conditioning: two flops for metastability plus a third stage; a
  // sample is only accepted when stages 2 and 3 agree, which filters out
  // single-cycle glitches and skew between the ten input bits.
  always_ff @(posedge clk or negedge total_reset) begin
    if (!total_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      acc_q   <= '0;
    end else begin
      sync1_q <= {finish, current_score1, current_score2};
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (sync2_q == sync3_q) begin
        acc_q <= sync2_q;
      end
    end
  end

  always_ff @(posedge clk or negedge total_reset) begin
    if (!total_reset) begin
      state_q <= PLAY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The winner is latched only when leaving PLAY, so a
  // 1<->2 swap during the banner never changes the reported winner.
  always_comb begin
    state_d    = state_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    winner_d   = winner_q;
    blinkCnt_d = blinkCnt_q;
    phase_d    = phase_q;
    toggles_d  = toggles_q;
    case (state_q)
      PLAY: begin
        blinkCnt_d = '0;
        phase_d    = 1'b0;
        toggles_d  = '0;
        if (finWin) begin
          state_d  = WIN_BLINK;
          winner_d = (accFinish == 2'd2);
          // The loser's digit keeps its last PLAY value.
          if (accFinish == 2'd2) begin
            d2_d = 4'd5;
          end else begin
            d1_d = 4'd5;
          end
        end else begin
          d1_d = accScore1;
          d2_d = accScore2;
        end
      end
      WIN_BLINK: begin
        if (!finWin) begin
          state_d    = PLAY;
          blinkCnt_d = '0;
          phase_d    = 1'b0;
          toggles_d  = '0;
        end else if (blinkCnt_q == BLINK_LAST) begin
          blinkCnt_d = '0;
          toggles_d  = toggles_q + 1'b1;
          if (toggles_q == HOLD_LAST) begin
            state_d = WAIT_CLR;
            phase_d = 1'b0;
          end else begin
            phase_d = ~phase_q;
          end
        end else begin
          blinkCnt_d = blinkCnt_q + 1'b1;
        end
      end
      WAIT_CLR: begin
        if (!finWin) begin
          state_d    = PLAY;
          blinkCnt_d = '0;
          phase_d    = 1'b0;
          toggles_d  = '0;
        end
      end
      default: begin
        state_d = PLAY;
      end
    endcase
  end

  // Digit scan runs in every state, independent of the FSM.
  always_comb begin
    scanCnt_d  = scanCnt_q + 1'b1;
    digitIdx_d = digitIdx_q;
    if (scanCnt_q == SCAN_LAST) begin
      scanCnt_d  = '0;
      digitIdx_d = digitIdx_q + 2'd1;
    end
  end

  // Output values are built from the next-state values so the registered
  // outputs always match the internal registers of the same cycle.
  always_comb begin
    winnerBlank = (state_d == WIN_BLINK) && phase_d;
    an_d        = 4'b1110;
    seg_d       = SEG_BLANK;
    case (digitIdx_d)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = (winnerBlank && winner_d) ? SEG_BLANK : decode(d2_d);
      end
      2'd1: an_d = 4'b1101;
      2'd2: an_d = 4'b1011;
      default: begin
        an_d  = 4'b0111;
        seg_d = (winnerBlank && !winner_d) ? SEG_BLANK : decode(d1_d);
      end
    endcase
    led_d  = (state_d == PLAY) ? 2'b00 : (winner_d ? 2'b10 : 2'b01);
    over_d = (state_d == WAIT_CLR);
  end

  always_ff @(posedge clk or negedge total_reset) begin
    if (!total_reset) begin
      d1_q       <= '0;
      d2_q       <= '0;
      winner_q   <= 1'b0;
      scanCnt_q  <= '0;
      digitIdx_q <= '0;
      blinkCnt_q <= '0;
      phase_q    <= 1'b0;
      toggles_q  <= '0;
      seg_q      <= 7'b1000000;
      an_q       <= 4'b1110;
      led_q      <= 2'b00;
      over_q     <= 1'b0;
    end else begin
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      winner_q   <= winner_d;
      scanCnt_q  <= scanCnt_d;
      digitIdx_q <= digitIdx_d;
      blinkCnt_q <= blinkCnt_d;
      phase_q    <= phase_d;
      toggles_q  <= toggles_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      led_q      <= led_d;
      over_q     <= over_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign winner_led = led_q;
  assign match_over = over_q;

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit-scan step.
REQ-002 Parameter BLINK_DIV, default 12500000: clk cycles per blink-phase toggle.
REQ-003 Parameter HOLD_BLINKS, default 6: blink-phase toggles shown before the banner goes steady.
REQ-004 The block SHALL have these ports:
- clk  in  1  system clock, rising edge.
- total_reset  in  1  asynchronous, active-low reset.
- current_score1  in  4  player-1 score from the score counter; asynchronous to clk.
- current_score2  in  4  player-2 score; asynchronous to clk.
- finish  in  2  0 = playing, 1 = player 1 won, 2 = player 2 won, 3 = treated as 0; asynchronous to clk.
- seg  out  7  segments gfedcba, active-low.
- an  out  4  digit anodes, active-low, one-hot.
- winner_led  out  2  bit0 = player 1 won, bit1 = player 2 won.
- match_over  out  1  high while the banner is steady.

Function
REQ-005 All 10 input bits SHALL pass through a 2-flop synchronizer, then a third register; a sample is accepted only when stages 2 and 3 agree.
REQ-006 A stable input change SHALL be accepted on the 4th rising clk edge after it and SHALL act on the FSM on the 5th.
REQ-007 Display registers d1/d2 SHALL load the accepted scores every cycle in PLAY only.
REQ-008 The scan counter SHALL count 0..SCAN_DIV-1; at terminal count it wraps to 0 and the digit index advances 0,1,2,3,0.
REQ-009 Anode mapping: index 0 -> an=1110 shows d2; index 3 -> an=0111 shows d1; indices 1 and 2 show blank (seg=1111111).
REQ-010 Decode SHALL follow standard active-low gfedcba for 0-9 (0=1000000, 5=0010010); values 10-15 SHALL show 'E' (0000110).
REQ-011 The FSM SHALL have states PLAY, WIN_BLINK and WAIT_CLR.
REQ-012 PLAY -> WIN_BLINK when accepted finish goes 0 -> 1 or 0 -> 2; the block latches the winner and forces the winner's d register to 5; the loser's d register holds its last PLAY value.
REQ-013 In WIN_BLINK the blink counter SHALL run 0..BLINK_DIV-1; each wrap toggles the blink phase and increments the toggle count; while the phase is 1 the winner's digit SHALL be blanked.
REQ-014 WIN_BLINK -> WAIT_CLR on the wrap that brings the toggle count to HOLD_BLINKS; the phase is forced to 0 and the winner's digit is steady.
REQ-015 WIN_BLINK or WAIT_CLR -> PLAY when accepted finish returns to 0; blink counter, phase and toggle count clear; a change from 1 to 2 (or 2 to 1) SHALL NOT re-latch the winner.
REQ-016 Accepted finish = 3 SHALL behave as 0 in every state.
REQ-017 winner_led SHALL be the one-hot latched winner in WIN_BLINK and WAIT_CLR, and 00 in PLAY.
REQ-018 match_over SHALL be 1 only in WAIT_CLR.
REQ-019 All outputs SHALL be registered, and the scan SHALL run in every state.

Reset
REQ-020 total_reset low SHALL immediately and asynchronously force:
- FSM = PLAY; synchronizers, d1, d2 = 0;
- scan counter, digit index, blink counter, blink phase, toggle count = 0;
- an = 1110, seg = 1000000, winner_led = 00, match_over = 0.
REQ-021 Reset asserted in any state SHALL abort that state, with no residual banner after release.
REQ-022 After release, the first input acceptance SHALL occur on the 4th clk edge.

Verification (SCAN_DIV=4, BLINK_DIV=8, HOLD_BLINKS=4)
REQ-023 Reset, then scores 3/2 held stable -> an cycles 1110, 1101, 1011, 0111 at 4-cycle steps; seg = 0100100 (2) at 1110 and 0110000 (3) at 0111.
REQ-024 Scores 4/1, then finish=1 with scores 0/0 -> WIN_BLINK at edge 5; d1 = 5, d2 = 1; winner_led = 01; digit 3 blanks on alternate 8-cycle phases.
REQ-025 Continuing REQ-024 -> after 4 toggles (32 cycles) match_over = 1, digit 3 steady 5; finish -> 0 then returns to PLAY, winner_led = 00, match_over = 0.
REQ-026 finish=2 during WIN_BLINK, then finish=1 -> no re-latch, winner_led stays 10; finish=3 -> PLAY.
REQ-027 total_reset pulsed low mid-WIN_BLINK -> outputs match REQ-020 asynchronously; score 12 shown afterwards -> seg = 0000110.
REQ-028 A 1-cycle glitch on finish -> no state change.
